// File: rtl/multi_lock_if.sv
// multi_lock_if: lock-key controller signal bundle between keyboard decoder and the lock FSM.
interface multi_lock_if #(parameter int N_LOCK = 3);
  logic [N_LOCK-1:0] key_down;
  logic              shift_down;
  logic              clear;
  logic [N_LOCK-1:0] lock_state;
  logic [N_LOCK-1:0] lock_led;
  logic [N_LOCK-1:0] toggled;
  logic              upper_mode;
  modport master (output key_down, shift_down, clear,
                  input  lock_state, lock_led, toggled, upper_mode);
  modport slave  (input  key_down, shift_down, clear,
                  output lock_state, lock_led, toggled, upper_mode);
endinterface

// File: rtl/multi_lock_fsm.sv
// multi_lock_fsm: N independent toggle locks with release debounce and Caps^Shift letter-case mode.
module multi_lock_fsm #(
  parameter int N_LOCK         = 3,
  parameter int DEBOUNCE       = 4,
  parameter int CAPS_IDX       = 0,
  parameter int LED_ACTIVE_LOW = 0
) (
  input logic        clk,
  input logic        rst_n,
  multi_lock_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  // Bit 1 of the encoding is the lock state, so lock_state comes straight off the register.
  typedef enum logic [1:0] {OFF = 2'b00, OFF_HELD = 2'b01, ON = 2'b10, ON_HELD = 2'b11} state_t;
  state_t            st_q [N_LOCK];
  state_t            st_d [N_LOCK];
  logic [CW-1:0]     cnt_q [N_LOCK];
  logic [CW-1:0]     cnt_d [N_LOCK];
  logic [N_LOCK-1:0] tog_d, tog_q, on_q, on_d;
  logic              up_q;
  always_comb begin
    for (int i = 0; i < N_LOCK; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      tog_d[i] = 1'b0;
      if (bus.clear) begin
        st_d[i]  = bus.key_down[i] ? OFF_HELD : OFF;
        cnt_d[i] = '0;
      end else if (st_q[i] == OFF || st_q[i] == ON) begin
        if (cnt_q[i] != '0)
          cnt_d[i] = bus.key_down[i] ? CW'(DEBOUNCE) : cnt_q[i] - CW'(1);
        else if (bus.key_down[i]) begin
          st_d[i]  = (st_q[i] == OFF) ? ON_HELD : OFF_HELD;
          tog_d[i] = 1'b1;
        end
      end else if (!bus.key_down[i]) begin
        st_d[i]  = (st_q[i] == OFF_HELD) ? OFF : ON;
        cnt_d[i] = CW'(DEBOUNCE);
      end
      on_d[i] = st_d[i][1];
      on_q[i] = st_q[i][1];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LOCK; i++) begin
        st_q[i]  <= OFF;
        cnt_q[i] <= '0;
      end
      tog_q <= '0;
      up_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_LOCK; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      tog_q <= tog_d;
      up_q  <= on_d[CAPS_IDX] ^ bus.shift_down;
    end
  end
  assign bus.lock_state = on_q;
  assign bus.lock_led   = on_q ^ {N_LOCK{LED_ACTIVE_LOW != 0}};
  assign bus.toggled    = tog_q;
  assign bus.upper_mode = up_q;
endmodule

// File: doc/multi_lock_fsm.md
# multi_lock_fsm

Parametrised lock-key controller for the keyboard datapath. It tracks N independent toggle locks (Caps, Num, Scroll, ...) from level-type key-held inputs, and toggles exactly once per physical press, with release debounce. It also produces the combined letter-case mode (Caps XOR Shift) for the ASCII/display stage. It sits between the keyboard decoder (key-held levels) and the character-mapping/LED logic, and generalises the single Caps-lock FSM.

## Interface
- N_LOCK, 3, number of lock channels (1..8)
- DEBOUNCE, 4, release-debounce length in clk cycles (>=1); counter width = clog2(DEBOUNCE+1)
- CAPS_IDX, 0, channel index whose state drives upper_mode
- LED_ACTIVE_LOW, 0, 1 inverts lock_led polarity
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- key_down  in  N_LOCK  per-channel level, 1 while the lock key is held (synchronous to clk)
- shift_down  in  1  level, 1 while either Shift is held
- clear  in  1  synchronous clear of all locks, one-cycle or level
- lock_state  out  N_LOCK  registered lock state, 1 = lock on
- lock_led  out  N_LOCK  lock_state XOR {N_LOCK{LED_ACTIVE_LOW}}
- toggled  out  N_LOCK  registered one-cycle pulse on each accepted toggle
- upper_mode  out  1  registered, 1 = uppercase letters (lock_state[CAPS_IDX] XOR shift_down)

## Operation
- Each channel runs an independent 4-state FSM, has its own debounce counter cnt, and shares no logic with other channels except clear.
- FSM states:
  - OFF: lock off, key released.
  - OFF_HELD: lock off, waiting for release.
  - ON: lock on, key released.
  - ON_HELD: lock on, waiting for release.
- Reset (async, rst_n=0):
  - All channels go to OFF with cnt=0.
  - lock_state=0, toggled=0, upper_mode=0.
  - lock_led = all-0, or all-1 when LED_ACTIVE_LOW=1.
- OFF / ON (settled states):
  - If cnt!=0 and key_down=1: reload cnt=DEBOUNCE and stay. This is a bounce; no toggle.
  - If cnt!=0 and key_down=0: decrement cnt.
  - If cnt==0 and key_down=1: toggle. OFF goes to ON_HELD, ON goes to OFF_HELD. toggled[i]=1 for one cycle.
  - If cnt==0 and key_down=0: hold.
- OFF_HELD / ON_HELD:
  - Stay while key_down=1. A held key never re-toggles, so there is no auto-repeat.
  - On key_down=0: go to OFF / ON respectively, with cnt=DEBOUNCE.
- lock_state[i] = 1 in ON and ON_HELD, 0 otherwise.
- clear=1 has priority over any toggle in the same cycle:
  - Every channel goes to OFF_HELD if key_down[i]=1, else OFF with cnt=0.
  - toggled=0 that cycle, even for channels that were on.
- Simultaneous presses on different channels toggle independently in the same cycle. toggled may then have several bits set.
- upper_mode is computed from the next-state value of lock_state[CAPS_IDX] and the current shift_down, and registered on the same edge.

## Timing
- Toggle latency:
  - key_down[i] rising is sampled at edge k while the channel is settled with cnt==0.
  - lock_state[i], toggled[i] and upper_mode are valid after edge k.
  - toggled[i] falls after edge k+1.
- Release debounce:
  - Release is sampled at edge r. The earliest next accepted press is sampled at edge r+DEBOUNCE+1.
  - A press sampled at edges r+1..r+DEBOUNCE is ignored and restarts the window.
- Shift: shift_down change at edge k is reflected in upper_mode after edge k (1-cycle register).
- Clear: effective at the edge where clear=1 is sampled. lock_state=0 is visible after that edge.
- Reset mid-press: after rst_n deasserts with key_down=1, the channel is in OFF with cnt=0, so the held key toggles on the first active edge. This is accepted behaviour; the decoder holds key_down=0 during reset.

## Test plan
- Reset, then key_down[0] high for 10 cycles -> lock_state=3'b001 after the first edge, toggled[0] high exactly 1 cycle, no further toggle while held.
- DEBOUNCE=4: release key 0, re-press 2 cycles later (bounce), hold 3 cycles, release, wait 6, press -> exactly one toggle, at the final press; lock_state[0] goes 1 -> 0.
- Caps on, shift_down pulses 1 for 3 cycles -> upper_mode reads 1,0,0,0,1 (one-cycle lag); caps off with shift held -> upper_mode=1.
- key_down=3'b111 in one cycle from reset -> lock_state=3'b111, toggled=3'b111 for one cycle; LED_ACTIVE_LOW=1 build gives lock_led=3'b000.
- Locks 3'b101 on, clear=1 coincident with key_down[1] press -> lock_state=3'b000, toggled=0; channel 1 toggles only after release plus DEBOUNCE and a new press.
- rst_n low asynchronously between edges while lock_state=3'b011 -> outputs clear immediately without a clock edge and stay 0 until a new press.
